// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  // Responder FSM: wait for a request, count down the latency, present the word.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  // Width of the latency down-counter; holds LATENCY-1 for LATENCY up to 15.
  localparam int LAT_W = 4;

  // Word index of a byte address: drop the byte offset and wrap modulo the
  // array depth (depth is a power of two, so the mask keeps the low index bits).
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                             input int unsigned depth);
    return (byte_addr >> 2) & (depth - 1);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side req/rdy/valid handshake between the fetch unit and the responder.
interface imem_responder_if #(
  parameter int bits = 32
) ();

  logic            proc_req;
  logic [bits-1:0] addr_in;
  logic            busy_inj;
  logic            mem_rdy;
  logic            valid;
  logic [bits-1:0] rdata;

  // Fetch unit side: issues requests, consumes responses.
  modport master (
    output proc_req, addr_in, busy_inj,
    input  mem_rdy, valid, rdata
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  proc_req, addr_in, busy_inj,
    output mem_rdy, valid, rdata
  );

endinterface

// File: rtl/imem_responder_array.sv
// Instruction storage: synchronous write, combinational (asynchronous) read.
module imem_array #(
  parameter  int bits  = 32,
  parameter  int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [bits-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [bits-1:0]  rdata
);

  logic [bits-1:0] mem [DEPTH];

  // Preload write port.
  // NOTE: the storage has no reset on purpose; clearing every word would need a
  // reset fan-out to the whole array and prevents mapping onto block RAM.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every reader of mem at this edge still
    // sees the pre-edge contents (this is what gives read-before-write).
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time and returns the
// addressed word with a one-cycle valid pulse LATENCY cycles after acceptance.
module imem_responder
  import imem_pkg::*;
#(
  parameter int bits    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_responder_if.slave       bus,
  input  logic                  we,
  input  logic [bits-1:0]       waddr,
  input  logic [bits-1:0]       wdata
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(LATENCY - 1);

  // Reject configurations the counter or the index mask cannot represent.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("imem_responder: DEPTH must be a power of two");
  end

  imem_state_t      state_q;
  logic [LAT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [bits-1:0]  rdata_q;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [bits-1:0]  rd_word;
  logic             accept;

  assign req_idx = IDX_W'(word_index(32'(bus.addr_in), DEPTH));
  assign wr_idx  = IDX_W'(word_index(32'(waddr), DEPTH));

  // Handshake outputs: ready only while idle and not throttled; valid in RESP.
  assign bus.mem_rdy = (state_q == IDLE) && !bus.busy_inj;
  assign bus.valid   = (state_q == RESP);
  assign bus.rdata   = rdata_q;

  assign accept = (state_q == IDLE) && bus.proc_req && bus.mem_rdy;

  // Read index: the incoming address while idle (needed when LATENCY is 1 and
  // RESP is entered on the accepting edge), the latched index otherwise.
  always_comb begin
    // NOTE: default assignment first so every path drives rd_idx; a missing
    // branch would otherwise infer a latch.
    rd_idx = idx_q;
    if (state_q == IDLE) rd_idx = req_idx;
  end

  imem_array #(
    .bits  (bits),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (wr_idx),
    .wdata (wdata),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  // Request FSM with latency counter; rdata is captured on the edge entering RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q <= req_idx;
            cnt_q <= LAT_LOAD;
            if (LATENCY == 1) begin
              state_q <= RESP;
              rdata_q <= rd_word;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q != '0) cnt_q <= cnt_q - LAT_W'(1);
          // The counter reaches zero on this edge: the response is due.
          if (cnt_q <= LAT_W'(1)) begin
            state_q <= RESP;
            rdata_q <= rd_word;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
